// File: rtl/rx_frame_fsm.sv
`default_nettype none
// ============================================================================
// rx_frame_fsm : parametrised UART receive frame sequencer (start/data/parity/
//                stop) with parity/framing check and one-cycle valid pulse.
// Revision     : 1.0
// ============================================================================
module rx_frame_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_detected,
  input  logic                  sampling_strobe,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  data_is_available,
  output logic                  is_parity_stage,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    run_par;
  logic                    parity_fail;
  logic                    frame_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      run_par           <= 1'b0;
      parity_fail       <= 1'b0;
      frame_fail        <= 1'b0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      parity_error      <= 1'b0;
      framing_error     <= 1'b0;
      data_is_available <= 1'b0;
      is_parity_stage   <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // Error flags are only meaningful alongside the valid pulse.
      data_valid        <= 1'b0;
      parity_error      <= 1'b0;
      framing_error     <= 1'b0;
      data_is_available <= (state == DATA);
      is_parity_stage   <= (state == PARITY);
      busy              <= (state != IDLE);

      case (state)
        IDLE: begin
          if (start_detected) begin
            state       <= START;
            bit_cnt     <= '0;
            run_par     <= 1'b0;
            parity_fail <= 1'b0;
            frame_fail  <= 1'b0;
          end
        end

        START: begin
          if (sampling_strobe) begin
            if (serial_in) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (sampling_strobe) begin
            shift_reg <= {serial_in, shift_reg[DATA_WIDTH-1:1]};
            run_par   <= run_par ^ serial_in;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        PARITY: begin
          if (sampling_strobe) begin
            if (PARITY_MODE == 2) parity_fail <= ~(run_par ^ serial_in);
            else                  parity_fail <= run_par ^ serial_in;
            state <= STOP;
          end
        end

        STOP: begin
          if (sampling_strobe) begin
            if (!serial_in) frame_fail <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              // The final stop sample is folded in directly; frame_fail only
              // covers the earlier stop bits at this point.
              state         <= IDLE;
              data_valid    <= 1'b1;
              data_out      <= shift_reg;
              parity_error  <= (PARITY_MODE != 0) && parity_fail;
              framing_error <= frame_fail | ~serial_in;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_legal_state: assert property (@(posedge clk)
    state inside {IDLE, START, DATA, PARITY, STOP});
  a_single_valid: assert property (@(posedge clk) disable iff (reset)
    data_valid |=> !data_valid);
  a_no_parity_err: assert property (@(posedge clk)
    (PARITY_MODE != 0) || !parity_error);

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_fsm.sv
`default_nettype none
// ============================================================================
// tb_rx_frame_fsm : directed bench for rx_frame_fsm (even/odd 8-bit, 7-bit
//                   no-parity 2-stop instances sharing one stimulus).
// Revision        : 1.0
// ============================================================================
module tb_rx_frame_fsm;

  logic clk = 1'b0;
  logic reset;
  logic start_detected;
  logic sampling_strobe;
  logic serial_in;

  logic [7:0] ev_data;
  logic       ev_dv, ev_pe, ev_fe, ev_dia, ev_par, ev_busy;
  logic [7:0] od_data;
  logic       od_dv, od_pe, od_fe, od_dia, od_par, od_busy;
  logic [6:0] w7_data;
  logic       w7_dv, w7_pe, w7_fe, w7_dia, w7_par, w7_busy;

  int checks = 0;
  int errors = 0;
  int w7_busy_cnt = 0;
  logic w7_par_seen = 1'b0;

  always #5 clk = ~clk;

  rx_frame_fsm #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .start_detected(start_detected),
    .sampling_strobe(sampling_strobe), .serial_in(serial_in),
    .data_out(ev_data), .data_valid(ev_dv), .parity_error(ev_pe),
    .framing_error(ev_fe), .data_is_available(ev_dia),
    .is_parity_stage(ev_par), .busy(ev_busy));

  rx_frame_fsm #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .start_detected(start_detected),
    .sampling_strobe(sampling_strobe), .serial_in(serial_in),
    .data_out(od_data), .data_valid(od_dv), .parity_error(od_pe),
    .framing_error(od_fe), .data_is_available(od_dia),
    .is_parity_stage(od_par), .busy(od_busy));

  rx_frame_fsm #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2)) u_w7 (
    .clk(clk), .reset(reset), .start_detected(start_detected),
    .sampling_strobe(sampling_strobe), .serial_in(serial_in),
    .data_out(w7_data), .data_valid(w7_dv), .parity_error(w7_pe),
    .framing_error(w7_fe), .data_is_available(w7_dia),
    .is_parity_stage(w7_par), .busy(w7_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic tick(input logic sd, input logic st, input logic si);
    start_detected  = sd;
    sampling_strobe = st;
    serial_in       = si;
    @(posedge clk);
    #1;
    if (w7_busy) w7_busy_cnt++;
    if (w7_par)  w7_par_seen = 1'b1;
  endtask

  // bits[0] is the start bit; each strobe is preceded by one quiet cycle.
  task automatic send_frame(input logic [15:0] bits, input int n, input logic last_sd);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      tick((i == n - 1) ? last_sd : 1'b0, 1'b1, bits[i]);
    end
  endtask

  function automatic logic [15:0] mk8(input logic [7:0] d, input logic p, input logic s);
    return {5'b0, s, p, d, 1'b0};
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_detected = 1'b0;
    sampling_strobe = 1'b0;
    serial_in = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("rst_data", 32'(ev_data), 32'h0);
    chk("rst_dv", 32'(ev_dv), 32'h0);
    chk("rst_busy", 32'(ev_busy), 32'h0);
    chk("rst_pe_fe", 32'({ev_pe, ev_fe}), 32'h0);

    // 1: 0xA5, correct even parity (four ones -> parity bit 0)
    send_frame(mk8(8'hA5, 1'b0, 1'b1), 11, 1'b0);
    chk("t1_dv", 32'(ev_dv), 32'h1);
    chk("t1_data", 32'(ev_data), 32'hA5);
    chk("t1_pe", 32'(ev_pe), 32'h0);
    chk("t1_fe", 32'(ev_fe), 32'h0);
    chk("t1_odd_pe", 32'(od_pe), 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    chk("t1_dv_fall", 32'(ev_dv), 32'h0);
    chk("t1_pe_outside", 32'(od_pe), 32'h0);
    chk("t1_hold", 32'(ev_data), 32'hA5);

    // 2: parity bit 1 -> even fails, odd passes
    send_frame(mk8(8'hA5, 1'b1, 1'b1), 11, 1'b0);
    chk("t2_dv", 32'(ev_dv), 32'h1);
    chk("t2_data", 32'(ev_data), 32'hA5);
    chk("t2_pe", 32'(ev_pe), 32'h1);
    chk("t2_odd_dv", 32'(od_dv), 32'h1);
    chk("t2_odd_pe", 32'(od_pe), 32'h0);

    // 3: 7-bit, no parity, stops 1,0 -> framing error
    pulse_reset();
    w7_busy_cnt = 0;
    w7_par_seen = 1'b0;
    send_frame({6'b0, 1'b0, 1'b1, 7'h3C, 1'b0}, 10, 1'b0);
    chk("t3_dv", 32'(w7_dv), 32'h1);
    chk("t3_data", 32'(w7_data), 32'h3C);
    chk("t3_fe", 32'(w7_fe), 32'h1);
    chk("t3_pe", 32'(w7_pe), 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("t3_busy_cycles", 32'(w7_busy_cnt), 32'd20);
    chk("t3_no_parity_stage", 32'(w7_par_seen), 32'h0);

    // 4: false start then 0x5A
    pulse_reset();
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("t4_busy_lag", 32'(ev_busy), 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    chk("t4_busy_fall", 32'(ev_busy), 32'h0);
    chk("t4_no_dv", 32'(ev_dv), 32'h0);
    send_frame(mk8(8'h5A, 1'b0, 1'b1), 11, 1'b0);
    chk("t4_dv", 32'(ev_dv), 32'h1);
    chk("t4_data", 32'(ev_data), 32'h5A);
    chk("t4_pe_fe", 32'({ev_pe, ev_fe}), 32'h0);

    // 5: reset during 4th data bit, then 0xFF
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b1);
    chk("t5_dia", 32'(ev_dia), 32'h1);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    chk("t5_rst_data", 32'(ev_data), 32'h0);
    chk("t5_rst_flags", 32'({ev_dv, ev_busy, ev_dia, ev_par, ev_pe, ev_fe}), 32'h0);
    send_frame(mk8(8'hFF, 1'b0, 1'b1), 11, 1'b0);
    chk("t5_dv", 32'(ev_dv), 32'h1);
    chk("t5_data", 32'(ev_data), 32'hFF);
    chk("t5_pe_fe", 32'({ev_pe, ev_fe}), 32'h0);

    // 6: back-to-back 0x00 / 0xFF; start coincident with final stop ignored
    send_frame(mk8(8'h00, 1'b0, 1'b1), 11, 1'b0);
    chk("t6a_dv", 32'(ev_dv), 32'h1);
    chk("t6a_data", 32'(ev_data), 32'h00);
    send_frame(mk8(8'hFF, 1'b0, 1'b1), 11, 1'b1);
    chk("t6b_dv", 32'(ev_dv), 32'h1);
    chk("t6b_data", 32'(ev_data), 32'hFF);
    chk("t6b_pe_fe", 32'({ev_pe, ev_fe}), 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("t6_coincident_ignored", 32'(ev_busy), 32'h0);
    chk("t6_dv_single", 32'(ev_dv), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
